// File: rtl/zpu_mem_ctrl.sv
// Memory-side bus controller for zpu_core: decodes each core access to on-chip RAM
// (1-cycle synchronous read) or to an external req/ack I/O bus with a timeout.
module zpu_mem_ctrl #(
  parameter int unsigned RAM_ADDR_BITS = 14,
  parameter int unsigned IO_TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_data_write_i,
  output logic [31:0]              mem_data_read_o,
  output logic                     mem_done_o,
  output logic                     bus_error_o,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
  output logic                     ram_we_o,
  output logic [31:0]              ram_wdata_o,
  input  logic [31:0]              ram_rdata_i,
  output logic [31:0]              io_addr_o,
  output logic [31:0]              io_wdata_o,
  output logic                     io_read_o,
  output logic                     io_write_o,
  input  logic                     io_ack_i,
  input  logic [31:0]              io_rdata_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LIMIT = CW'(IO_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RAM_RD  = 2'd1;
  localparam logic [1:0] ST_IO_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          berr_q, berr_d;
  logic [DW-1:0] io_addr_q, io_addr_d;
  logic [DW-1:0] io_wdata_q, io_wdata_d;
  logic          io_read_q, io_read_d;
  logic          io_write_q, io_write_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ram_we_c;
  logic          io_sel;

  // Bit 31 splits the map; RAM ignores every other bit above the word index.
  assign io_sel = mem_addr_i[31];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      berr_q     <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_read_q  <= 1'b0;
      io_write_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      berr_q     <= berr_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_read_q  <= io_read_d;
      io_write_q <= io_write_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and datapath updates; a simultaneous read and write is served as a write.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    berr_d     = 1'b0;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_read_d  = io_read_q;
    io_write_d = io_write_q;
    cnt_d      = cnt_q;
    ram_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_write_i || mem_read_i) begin
          if (io_sel) begin
            io_addr_d  = mem_addr_i;
            io_wdata_d = mem_data_write_i;
            io_write_d = mem_write_i;
            io_read_d  = ~mem_write_i;
            cnt_d      = '0;
            state_d    = ST_IO_WAIT;
          end else if (mem_write_i) begin
            ram_we_c = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RAM_RD;
          end
        end
      end

      ST_RAM_RD: begin
        rdata_d = ram_rdata_i;
        state_d = ST_DONE;
      end

      ST_IO_WAIT: begin
        // An ack on the final allowed cycle still completes successfully.
        if (io_ack_i) begin
          if (io_read_q) begin
            rdata_d = io_rdata_i;
          end
          io_read_d  = 1'b0;
          io_write_d = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_q == TO_LIMIT) begin
          if (io_read_q) begin
            rdata_d = 32'hFFFF_FFFF;
          end
          io_read_d  = 1'b0;
          io_write_d = 1'b0;
          berr_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_done_o      = (state_q == ST_DONE);
  assign bus_error_o     = berr_q;
  assign mem_data_read_o = rdata_q;
  assign io_addr_o       = io_addr_q;
  assign io_wdata_o      = io_wdata_q;
  assign io_read_o       = io_read_q;
  assign io_write_o      = io_write_q;
  assign ram_we_o        = ram_we_c;
  assign ram_addr_o      = mem_addr_i[RAM_ADDR_BITS+1:2];
  assign ram_wdata_o     = mem_data_write_i;

endmodule

// File: tb/tb_zpu_mem_ctrl.sv
// Bench for zpu_mem_ctrl: directed scenarios plus random RAM/I/O traffic checked
// against a word-indexed memory model and access-latency rules.
module tb_zpu_mem_ctrl;

  localparam int unsigned RAB    = 8;
  localparam int unsigned IO_TO  = 8;
  localparam int unsigned WORDS  = 256;

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_read, mem_write;
  logic [31:0]    mem_addr, mem_data_write, mem_data_read;
  logic           mem_done, bus_error;
  logic [RAB-1:0] ram_addr;
  logic           ram_we;
  logic [31:0]    ram_wdata, ram_rdata;
  logic [31:0]    io_addr, io_wdata;
  logic           io_read, io_write, io_ack;
  logic [31:0]    io_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc;

  logic [31:0] ram_mem [WORDS];
  logic [31:0] model_ram [int];
  logic [31:0] model_rdata;
  int          written [$];

  zpu_mem_ctrl #(.RAM_ADDR_BITS(RAB), .IO_TIMEOUT(IO_TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .mem_read_i(mem_read), .mem_write_i(mem_write),
    .mem_addr_i(mem_addr), .mem_data_write_i(mem_data_write),
    .mem_data_read_o(mem_data_read), .mem_done_o(mem_done), .bus_error_o(bus_error),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .io_addr_o(io_addr), .io_wdata_o(io_wdata), .io_read_o(io_read), .io_write_o(io_write),
    .io_ack_i(io_ack), .io_rdata_i(io_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access; ack_dly = strobe cycles before io_ack (negative: never acked).
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_dly,
                        input logic [31:0] io_rd, input bit keep);
    bit          is_io;
    bit          done;
    bit          exp_berr;
    int          exp_lat;
    int          idx;
    logic [31:0] exp_data;
    is_io    = addr[31];
    idx      = int'((addr / 32'd4) % WORDS);
    exp_berr = 1'b0;
    if (!is_io) exp_lat = wr ? 1 : 2;
    else if (ack_dly >= 0 && ack_dly < int'(IO_TO)) exp_lat = 2 + ack_dly;
    else begin
      exp_lat  = int'(IO_TO) + 1;
      exp_berr = 1'b1;
    end
    if (wr) exp_data = model_rdata;
    else if (!is_io) exp_data = model_ram.exists(idx) ? model_ram[idx] : 32'h0;
    else if (exp_berr) exp_data = 32'hFFFF_FFFF;
    else exp_data = io_rd;

    @(posedge clk); #1;
    check("idle_done", {31'b0, mem_done}, 32'd0);
    check("idle_berr", {31'b0, bus_error}, 32'd0);
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = addr;
    mem_data_write = wdata;
    io_rdata       = $urandom;
    if (!is_io) io_ack = 1'($urandom_range(0, 1));
    #1;
    check("ram_we", {31'b0, ram_we}, {31'b0, !is_io && wr});
    if (!is_io) check("ram_addr", {24'b0, ram_addr}, 32'(idx));

    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      io_ack = 1'b0;
      if (mem_done) begin
        done = 1'b1;
        check("latency", 32'(c), 32'(exp_lat));
        check("bus_error", {31'b0, bus_error}, {31'b0, exp_berr});
        check("rdata", mem_data_read, exp_data);
        if (is_io) check("strobes_off", {30'b0, io_read, io_write}, 32'd0);
        last_done_cyc = cyc;
      end else if (is_io) begin
        check("io_read", {31'b0, io_read}, {31'b0, !wr});
        check("io_write", {31'b0, io_write}, {31'b0, wr});
        if (c == 1) begin
          check("io_addr", io_addr, addr);
          check("io_wdata", io_wdata, wdata);
        end
      end
      if (is_io && !done && ack_dly >= 0 && c == 1 + ack_dly) begin
        io_ack   = 1'b1;
        io_rdata = io_rd;
      end
    end
    check("done_seen", {31'b0, done}, 32'd1);

    if (wr && !is_io) begin
      model_ram[idx] = wdata;
      written.push_back(idx);
    end
    model_rdata = exp_data;
    if (!keep) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  initial begin
    int prev_done;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
    mem_data_write = '0; io_ack = 1'b0; io_rdata = '0;
    model_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'b0, mem_done}, 32'd0);
    check("rst_berr", {31'b0, bus_error}, 32'd0);
    check("rst_strobes", {30'b0, io_read, io_write}, 32'd0);
    check("rst_rdata", mem_data_read, 32'd0);
    check("rst_io_addr", io_addr, 32'd0);
    check("rst_io_wdata", io_wdata, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    reset = 1'b0;

    // RAM write then read-back
    access(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, -1, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0, -1, 32'h0, 1'b0);
    // I/O read acked three cycles into the strobe
    access(1'b0, 1'b1, 32'h8000_0004, 32'h0, 3, 32'h1234_5678, 1'b0);
    // I/O write and read that both time out
    access(1'b1, 1'b0, 32'h8000_0000, 32'hCAFE_F00D, -1, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h8000_0008, 32'h0, -1, 32'h0, 1'b0);
    // Ack on the last allowed cycle wins over the timeout
    access(1'b0, 1'b1, 32'h8000_000C, 32'h0, int'(IO_TO) - 1, 32'hA5A5_5A5A, 1'b0);
    // Aliased RAM address and simultaneous read+write
    access(1'b1, 1'b1, 32'h7FFF_FC08, 32'h1111_2222, -1, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0008, 32'h0, -1, 32'h0, 1'b0);

    // Back-to-back reads with mem_read held high
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0AAA, -1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0000_0BBB, -1, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0000_0CCC, -1, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0000, 32'h0, -1, 32'h0, 1'b1);
    prev_done = last_done_cyc;
    for (int w = 1; w < 3; w++) begin
      access(1'b0, 1'b1, 32'(w * 4), 32'h0, -1, 32'h0, (w < 2));
      check("b2b_gap", 32'(last_done_cyc - prev_done), 32'd3);
      prev_done = last_done_cyc;
    end

    // Reset two cycles into an I/O wait
    @(posedge clk); #1;
    mem_read = 1'b1; mem_addr = 32'h8000_0010;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_io_read", {31'b0, io_read}, 32'd1);
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_io_read", {31'b0, io_read}, 32'd0);
    check("rst_mid_done", {31'b0, mem_done}, 32'd0);
    check("rst_mid_rdata", mem_data_read, 32'd0);
    model_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_no_done", {31'b0, mem_done}, 32'd0);
    end
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0, -1, 32'h0, 1'b0);

    // Random traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      int          kind;
      int          idx;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      if (kind == 1 && written.size() == 0) kind = 0;
      case (kind)
        0: begin
          a = {1'b0, 21'($urandom), 8'($urandom), 2'($urandom)};
          access(1'b1, 1'($urandom_range(0, 1)), a, $urandom, -1, 32'h0, 1'b0);
        end
        1: begin
          idx = written[$urandom_range(0, written.size() - 1)];
          a   = {1'b0, 21'($urandom), 8'(idx), 2'($urandom)};
          access(1'b0, 1'b1, a, 32'h0, -1, 32'h0, 1'b0);
        end
        2: access(1'b0, 1'b1, {1'b1, 31'($urandom)}, $urandom,
                  int'($urandom_range(0, IO_TO + 1)) - 1, $urandom, 1'b0);
        default: access(1'b1, 1'($urandom_range(0, 1)), {1'b1, 31'($urandom)}, $urandom,
                        int'($urandom_range(0, IO_TO + 1)) - 1, $urandom, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
